// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime baud divisor, 5-8 data bits, optional parity,
// first-word fall-through receive FIFO and sticky error flags.
module uart_rx_fifo #(
   parameter int DIV_WIDTH  = 16,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic [1:0]           data_bits,
   input  logic [1:0]           parity_mode,
   input  logic                 serial_in,
   input  logic                 buffer_read,
   input  logic                 error_clear,
   output logic [7:0]           data_out,
   output logic                 buffer_data_present,
   output logic                 buffer_half_full,
   output logic                 buffer_full,
   output logic [DEPTH_LOG2:0]  buffer_level,
   output logic                 frame_error,
   output logic                 parity_error,
   output logic                 overrun
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] LVL_HALF = (DEPTH_LOG2+1)'(DEPTH / 2);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t                state, state_nx;
   logic [DIV_WIDTH-1:0]  tick_cnt, tick_lim;
   logic                  tick;
   logic [1:0]            sync;
   logic                  rx;
   logic [3:0]            os;
   logic [2:0]            bit_idx, last_idx;
   logic [7:0]            shreg;
   logic [1:0]            db_q, pm_q;
   logic                  par_q, par_en, par_exp, par_bad;
   logic                  stop_dec, wr_req, fe_set, pe_set, ovr_set;
   logic                  do_wr, do_rd;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   level;

   assign tick_lim = (baud_div == '0) ? '0 : baud_div - 1'b1;
   assign tick     = tick_cnt >= tick_lim;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) tick_cnt <= '0;
      else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync <= 2'b11;
      else       sync <= {sync[0], serial_in};
   end

   assign rx       = sync[1];
   assign last_idx = 3'd4 + {1'b0, db_q};
   assign par_en   = pm_q[0] ^ pm_q[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (tick) begin
         unique case (state)
            S_IDLE:   if (!rx) state_nx = S_START;
            S_START:  if (os == 4'd7) state_nx = rx ? S_IDLE : S_DATA;
            S_DATA:   if (os == 4'hF && bit_idx == last_idx)
                         state_nx = par_en ? S_PARITY : S_STOP;
            S_PARITY: if (os == 4'hF) state_nx = S_STOP;
            S_STOP:   if (os == 4'hF) state_nx = rx ? S_IDLE : S_BREAK;
            S_BREAK:  if (rx) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
         endcase
      end
   end

   // shreg upper bits stay zero, so XOR over all 8 bits is the data parity
   always_comb begin
      stop_dec = (state == S_STOP) && tick && (os == 4'hF);
      par_exp  = (^shreg) ^ pm_q[1];
      par_bad  = par_en && (par_q != par_exp);
      fe_set   = stop_dec && !rx;
      pe_set   = stop_dec && rx && par_bad;
      wr_req   = stop_dec && rx && !par_bad;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         os      <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         db_q    <= '0;
         pm_q    <= '0;
         par_q   <= 1'b0;
      end else if (tick) begin
         if (state == S_IDLE || (state == S_START && os == 4'd7))
            os <= '0;
         else
            os <= os + 1'b1;
         if (state == S_IDLE) begin
            bit_idx <= '0;
            shreg   <= '0;
            if (!rx) begin
               db_q <= data_bits;
               pm_q <= parity_mode;
            end
         end
         if (state == S_DATA && os == 4'hF) begin
            shreg[bit_idx] <= rx;
            bit_idx        <= bit_idx + 1'b1;
         end
         if (state == S_PARITY && os == 4'hF)
            par_q <= rx;
      end
   end

   // a read on the decision cycle frees the slot for the incoming byte
   assign do_rd   = buffer_read && (level != '0);
   assign do_wr   = wr_req && (level != LVL_FULL || buffer_read);
   assign ovr_set = wr_req && (level == LVL_FULL) && !buffer_read;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_error  <= 1'b0;
         parity_error <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         frame_error  <= fe_set  | (frame_error  & ~error_clear);
         parity_error <= pe_set  | (parity_error & ~error_clear);
         overrun      <= ovr_set | (overrun      & ~error_clear);
      end
   end

   assign buffer_level        = level;
   assign buffer_data_present = level != '0;
   assign buffer_half_full    = level >= LVL_HALF;
   assign buffer_full         = level == LVL_FULL;
   assign data_out            = buffer_data_present ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of frames plus hand sequences
// for break, overrun, read-on-full, glitch and mid-frame reset.
module tb_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] baud_div = 16'd4;
   logic [1:0]  data_bits = 2'd3;
   logic [1:0]  parity_mode = 2'd0;
   logic        serial_in = 1'b1;
   logic        buffer_read = 1'b0;
   logic        error_clear = 1'b0;
   logic [7:0]  data_out;
   logic        buffer_data_present;
   logic        buffer_half_full;
   logic        buffer_full;
   logic [2:0]  buffer_level;
   logic        frame_error;
   logic        parity_error;
   logic        overrun;

   int n_cmp = 0;
   int n_bad = 0;

   uart_rx_fifo #(.DIV_WIDTH(16), .DEPTH_LOG2(2)) dut (
      .clk(clk),
      .reset(reset),
      .baud_div(baud_div),
      .data_bits(data_bits),
      .parity_mode(parity_mode),
      .serial_in(serial_in),
      .buffer_read(buffer_read),
      .error_clear(error_clear),
      .data_out(data_out),
      .buffer_data_present(buffer_data_present),
      .buffer_half_full(buffer_half_full),
      .buffer_full(buffer_full),
      .buffer_level(buffer_level),
      .frame_error(frame_error),
      .parity_error(parity_error),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] db;
      logic [1:0] pm;
      logic [7:0] d;
      bit         bad;
      int         lvl;
      logic [7:0] head;
      bit         pe;
      bit         pop;
      bit         clr;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_data"}, {24'h0, data_out}, 32'h0);
      chk({p, "_present"}, {31'h0, buffer_data_present}, 32'h0);
      chk({p, "_half"}, {31'h0, buffer_half_full}, 32'h0);
      chk({p, "_full"}, {31'h0, buffer_full}, 32'h0);
      chk({p, "_level"}, {29'h0, buffer_level}, 32'h0);
      chk({p, "_fe"}, {31'h0, frame_error}, 32'h0);
      chk({p, "_pe"}, {31'h0, parity_error}, 32'h0);
      chk({p, "_ovr"}, {31'h0, overrun}, 32'h0);
   endtask

   task automatic bit_out(input logic v, input int bclk);
      serial_in = v;
      repeat (bclk) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] db,
                             input logic [1:0] pm, input bit bad,
                             input bit stop_low, input int bclk);
      int nb;
      logic [7:0] m;
      logic p;
      nb = 5 + int'(db);
      m = d & 8'((1 << nb) - 1);
      p = (^m) ^ (pm == 2'd2) ^ bad;
      data_bits = db;
      parity_mode = pm;
      bit_out(1'b0, bclk);
      for (int i = 0; i < nb; i++) bit_out(d[i], bclk);
      if (pm == 2'd1 || pm == 2'd2) bit_out(p, bclk);
      bit_out(!stop_low, bclk);
   endtask

   task automatic pulse_rd();
      buffer_read = 1'b1;
      @(posedge clk);
      #1;
      buffer_read = 1'b0;
   endtask

   task automatic pulse_clr();
      error_clear = 1'b1;
      @(posedge clk);
      #1;
      error_clear = 1'b0;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      tbl[0] = '{2'd3, 2'd0, 8'h55, 1'b0, 1, 8'h55, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{2'd2, 2'd2, 8'h41, 1'b0, 1, 8'h41, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{2'd2, 2'd2, 8'h41, 1'b1, 1, 8'h41, 1'b1, 1'b1, 1'b1};
      tbl[3] = '{2'd0, 2'd0, 8'hFF, 1'b0, 1, 8'h1F, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{2'd1, 2'd1, 8'h2A, 1'b0, 1, 8'h2A, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{2'd3, 2'd3, 8'hC7, 1'b0, 1, 8'hC7, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{2'd3, 2'd1, 8'hA5, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b1};
      tbl[7] = '{2'd1, 2'd2, 8'h3F, 1'b0, 1, 8'h3F, 1'b0, 1'b1, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk_zero("rst");
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      k = 0;
      fork
         send_frame(8'h55, 2'd3, 2'd0, 1'b0, 1'b0, 64);
         begin
            while (!buffer_data_present && k < 640) begin
               @(posedge clk);
               #1;
               k++;
            end
         end
      join
      chk("lat_window", {31'h0, (k >= 600 && k <= 620)}, 32'h1);
      chk("lat_data", {24'h0, data_out}, 32'h55);
      chk("lat_level", {29'h0, buffer_level}, 32'h1);
      pulse_rd();
      chk("lat_pop_level", {29'h0, buffer_level}, 32'h0);
      chk("lat_pop_data", {24'h0, data_out}, 32'h0);

      for (int i = 0; i < 8; i++) begin
         send_frame(tbl[i].d, tbl[i].db, tbl[i].pm, tbl[i].bad, 1'b0, 64);
         repeat (2) @(posedge clk);
         #1;
         chk($sformatf("v%0d_level", i), {29'h0, buffer_level}, tbl[i].lvl);
         chk($sformatf("v%0d_head", i), {24'h0, data_out},
             {24'h0, tbl[i].head});
         chk($sformatf("v%0d_pe", i), {31'h0, parity_error},
             {31'h0, tbl[i].pe});
         chk($sformatf("v%0d_fe", i), {31'h0, frame_error}, 32'h0);
         if (tbl[i].pop) pulse_rd();
         if (tbl[i].clr) pulse_clr();
      end

      send_frame(8'h1F, 2'd0, 2'd0, 1'b0, 1'b1, 64);
      chk("brk_fe", {31'h0, frame_error}, 32'h1);
      chk("brk_level", {29'h0, buffer_level}, 32'h0);
      pulse_clr();
      repeat (192) @(posedge clk);
      #1;
      chk("brk_no_refe", {31'h0, frame_error}, 32'h0);
      serial_in = 1'b1;
      repeat (64) @(posedge clk);
      #1;
      send_frame(8'h0A, 2'd0, 2'd0, 1'b0, 1'b0, 64);
      chk("brk_after_level", {29'h0, buffer_level}, 32'h1);
      chk("brk_after_data", {24'h0, data_out}, 32'h0A);
      chk("brk_after_fe", {31'h0, frame_error}, 32'h0);
      pulse_rd();

      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 2'd3, 2'd0, 1'b0, 1'b0, 64);
         chk($sformatf("ovr%0d_level", i), {29'h0, buffer_level},
             (i > 4) ? 4 : i);
         chk($sformatf("ovr%0d_full", i), {31'h0, buffer_full},
             (i >= 4) ? 1 : 0);
         chk($sformatf("ovr%0d_half", i), {31'h0, buffer_half_full},
             (i >= 2) ? 1 : 0);
         chk($sformatf("ovr%0d_flag", i), {31'h0, overrun},
             (i == 5) ? 1 : 0);
      end
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("ovr_rd%0d", i), {24'h0, data_out}, i);
         pulse_rd();
      end
      chk("ovr_empty_level", {29'h0, buffer_level}, 32'h0);
      chk("ovr_empty_data", {24'h0, data_out}, 32'h0);
      pulse_clr();
      chk("ovr_cleared", {31'h0, overrun}, 32'h0);

      baud_div = 16'd2;
      send_frame(8'h3C, 2'd3, 2'd0, 1'b0, 1'b0, 32);
      chk("b2_level", {29'h0, buffer_level}, 32'h1);
      chk("b2_data", {24'h0, data_out}, 32'h3C);
      pulse_rd();

      baud_div = 16'd0;
      for (int j = 1; j <= 4; j++)
         send_frame(8'(j * 17), 2'd3, 2'd0, 1'b0, 1'b0, 16);
      chk("rw_pre_level", {29'h0, buffer_level}, 32'h4);
      @(posedge clk);
      #1;
      fork
         send_frame(8'h99, 2'd3, 2'd0, 1'b0, 1'b0, 16);
         begin
            repeat (154) @(posedge clk);
            #1;
            buffer_read = 1'b1;
            @(posedge clk);
            #1;
            buffer_read = 1'b0;
         end
      join
      chk("rw_ovr", {31'h0, overrun}, 32'h0);
      chk("rw_level", {29'h0, buffer_level}, 32'h4);
      for (int j = 2; j <= 5; j++) begin
         chk($sformatf("rw_rd%0d", j), {24'h0, data_out},
             (j == 5) ? 32'h99 : j * 17);
         pulse_rd();
      end

      baud_div = 16'd4;
      repeat (20) @(posedge clk);
      #1;
      serial_in = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      serial_in = 1'b1;
      repeat (640) @(posedge clk);
      #1;
      chk("gl_level", {29'h0, buffer_level}, 32'h0);
      chk("gl_fe", {31'h0, frame_error}, 32'h0);
      chk("gl_pe", {31'h0, parity_error}, 32'h0);

      send_frame(8'hA5, 2'd3, 2'd1, 1'b1, 1'b0, 64);
      send_frame(8'h77, 2'd3, 2'd0, 1'b0, 1'b0, 64);
      chk("mr_pre_pe", {31'h0, parity_error}, 32'h1);
      chk("mr_pre_level", {29'h0, buffer_level}, 32'h1);
      fork
         send_frame(8'h12, 2'd3, 2'd0, 1'b0, 1'b0, 64);
         begin
            repeat (200) @(posedge clk);
            #1;
            reset = 1'b1;
            #2;
            chk_zero("midrst");
         end
      join
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      send_frame(8'h5A, 2'd3, 2'd0, 1'b0, 1'b0, 64);
      chk("mr_post_level", {29'h0, buffer_level}, 32'h1);
      chk("mr_post_data", {24'h0, data_out}, 32'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated baud-tick generator and receive FIFO. It is the next-generation replacement for the fixed 8N1, 16-deep receive path and the separate baud generator on the Nexys4 command-and-control hub. It adds a runtime baud divisor, 5–8 data bits, optional even/odd parity, configurable FIFO depth, an occupancy count, and sticky framing, parity and overrun flags. The hub reads it through the same read-strobe style interface as the existing receive buffer.

## Interface
- DIV_WIDTH, 16, width of the runtime baud divisor
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (legal range 2..8)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- baud_div  in  DIV_WIDTH  16x-oversample tick period in clk cycles; 0 and 1 both mean a tick every clock
- data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
- serial_in  in  1  asynchronous RX line, idle high
- buffer_read  in  1  pops the FIFO head (one-cycle strobe)
- error_clear  in  1  clears all sticky error flags
- data_out  out  8  FIFO head, first-word fall-through, LSB-aligned, unused high bits 0; reads 8'h00 when the FIFO is empty
- buffer_data_present  out  1  FIFO level != 0
- buffer_half_full  out  1  level >= DEPTH/2
- buffer_full  out  1  level == DEPTH
- buffer_level  out  DEPTH_LOG2+1  current occupancy
- frame_error, parity_error, overrun  out  1 each  sticky error flags

## Operation
- Reset values:
  - All outputs are 0.
  - Synchroniser flops reset to 1.
  - FSM is in IDLE.
  - Tick counter, oversample counter and FIFO pointers are 0.
- Baud tick:
  - Counter increments every clk.
  - When counter >= max(baud_div,1)-1, the tick pulses for one cycle and the counter returns to 0.
  - A baud_div change mid-frame takes effect on the next compare; no glitch is required beyond that.
- serial_in passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- All FSM activity advances only on tick cycles. The oversample count `os` runs 0..15 per bit.
- FSM states and transitions:
  - IDLE: a low line on a tick goes to START with os=0.
  - START: at os=7 (mid-bit), a line that is still low goes to DATA with os=0 and bit index 0. A high line is a false start and returns to IDLE with no flag.
  - DATA: sample at os=15 (one bit period later, mid-bit). Bits shift in LSB first. After the data_bits-th bit, go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: sample at os=15. Expected value is XOR of the data bits for even, and its inverse for odd.
  - STOP: sample at os=15 and evaluate the frame:
    - Line low: set frame_error, discard the byte, go to BREAK.
    - Parity mismatch: set parity_error, discard the byte, go to IDLE.
    - Otherwise write the byte to the FIFO and go to IDLE.
  - BREAK: wait until the line reads high on a tick, then go to IDLE. This suppresses repeated frame errors during a break.
- FIFO write rules:
  - A write occurs on the same cycle as the STOP decision.
  - If the FIFO is full and buffer_read is not asserted that cycle, the byte is dropped and overrun is set.
  - If the FIFO is full and buffer_read is asserted that cycle, the write is accepted and the level stays at DEPTH.
- FIFO read rules:
  - buffer_read on an empty FIFO is ignored; the level stays 0 with no underflow.
  - Simultaneous read and write on a non-empty FIFO keeps the level unchanged.
  - Pointers wrap modulo DEPTH.
- Error flags: error_clear zeroes all three flags. If error_clear coincides with a new error on the same cycle, the set wins.
- Config inputs (data_bits, parity_mode) are sampled when leaving IDLE and held for the whole frame. Changes mid-frame do not affect that frame.
- Reset asserted mid-frame aborts the frame and empties the FIFO. After release the block waits in IDLE for a falling edge.

## Timing
- Input synchroniser latency: 2 clk.
- Bit period: 16 ticks. The start edge is detected within one tick of the synchronised fall.
- The STOP sample occurs (0.5 + data_bits + parity + 1) bit periods after detection, in ticks.
- Write-to-visibility: buffer_data_present, buffer_level and data_out update on the clk edge after the STOP decision cycle (1 cycle).
- Read: on the edge that samples buffer_read, the level decrements and data_out shows the next entry (or 8'h00) in the following cycle.
- Status flags (present, half_full, full) are derived from the registered level with no extra latency.

## Test plan
- baud_div=4 (tick every 4 clk, bit = 64 clk), 8N1, send 0x55: data_out=0x55 with buffer_data_present=1 and level=1 within 9.5 bit periods (~610 clk) of the start edge. buffer_read then returns level to 0 and data_out to 0x00.
- 7 data bits, odd parity, send 0x41 with correct parity then 0x41 with wrong parity: first frame is stored as 0x41, second sets parity_error=1 and is not stored (level stays 1). error_clear returns the flag to 0.
- 5 bits, no parity, send 0x1F with stop bit forced low, then hold the line low for 3 bit times: frame_error=1 exactly once, nothing stored. Afterwards a valid 0x0A frame is received correctly after the line returns high.
- DEPTH_LOG2=2: send 5 bytes 0x01..0x05 with no reads: full=1 and level=4 after the 4th byte; 5th is dropped with overrun=1. Reads return 0x01..0x04 in order.
- With the FIFO full, assert buffer_read on the exact STOP-decision cycle of byte 0x99: no overrun, level stays 4, and 0x99 is last out.
- A 2-tick low glitch on an idle line produces no byte and no flag. Reset asserted mid-frame clears all outputs to 0 immediately (async). Changing baud_div from 4 to 2 between frames doubles the bit rate with correct reception.
